// File: rtl/roulette_round_controller_if.sv
// Handshake bundle between the keyboard/Arduino/wheel/payout side and the round controller.
// The controller connects through the slave modport; the driving environment uses master.
interface roulette_round_controller_if;
  logic       key_valid;
  logic [5:0] bet_opcode;
  logic [2:0] chip_color;
  logic       spin_done;
  logic [5:0] result_number;
  logic       payout_done;
  logic       bet_wen;
  logic [3:0] bet_idx;
  logic [7:0] bet_data;
  logic [3:0] bet_count;
  logic       spin_req;
  logic [5:0] result_latch;
  logic       payout_start;
  logic       clear_bets;
  logic       reject;
  logic [2:0] state;

  modport master (
    output key_valid, bet_opcode, chip_color, spin_done, result_number, payout_done,
    input  bet_wen, bet_idx, bet_data, bet_count, spin_req, result_latch,
           payout_start, clear_bets, reject, state
  );

  modport slave (
    input  key_valid, bet_opcode, chip_color, spin_done, result_number, payout_done,
    output bet_wen, bet_idx, bet_data, bet_count, spin_req, result_latch,
           payout_start, clear_bets, reject, state
  );
endinterface

// File: rtl/roulette_round_controller.sv
// Sequences one roulette round (BETTING, SPIN, SETTLE, PAYOUT, HOLD, CLEAR) and
// gates decoded key presses into a counted bet-slot write port. All outputs registered.
module roulette_round_controller #(
  parameter int          MAX_BETS       = 12,
  parameter logic [31:0] SPIN_TIMEOUT   = 32'd500_000_000,
  parameter logic [31:0] DISPLAY_CYCLES = 32'd200_000_000
) (
  input logic                          clock,
  input logic                          reset,
  roulette_round_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_BETTING = 3'd0,
    ST_SPIN    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PAYOUT  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_CLEAR   = 3'd5
  } state_t;

  localparam logic [5:0] OP_NONE  = 6'b111111;
  localparam logic [5:0] OP_SPIN  = 6'b111110;
  localparam logic [5:0] OP_CLEAR = 6'b111101;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_BETS);

  state_t      r_state,  w_state;
  logic [31:0] r_timer,  w_timer;
  logic [3:0]  r_count,  w_count;
  logic        r_bet_wen, w_bet_wen;
  logic [3:0]  r_bet_idx, w_bet_idx;
  logic [7:0]  r_bet_data, w_bet_data;
  logic        r_spin_req, w_spin_req;
  logic [5:0]  r_result, w_result;
  logic        r_payout, w_payout;
  logic        r_clear,  w_clear;
  logic        r_reject, w_reject;
  logic        w_valid_spin;

  // Pockets 0..37 only; anything above is a glitch from the wheel sensor.
  assign w_valid_spin = bus.spin_done && (bus.result_number <= 6'd37);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_BETTING;
      r_timer    <= '0;
      r_count    <= '0;
      r_bet_wen  <= 1'b0;
      r_bet_idx  <= '0;
      r_bet_data <= '0;
      r_spin_req <= 1'b0;
      r_result   <= '0;
      r_payout   <= 1'b0;
      r_clear    <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_count    <= w_count;
      r_bet_wen  <= w_bet_wen;
      r_bet_idx  <= w_bet_idx;
      r_bet_data <= w_bet_data;
      r_spin_req <= w_spin_req;
      r_result   <= w_result;
      r_payout   <= w_payout;
      r_clear    <= w_clear;
      r_reject   <= w_reject;
    end
  end

  // Pulses are computed alongside the next state so they line up with the state they belong to.
  always_comb begin
    w_state    = r_state;
    w_timer    = r_timer;
    w_count    = r_count;
    w_bet_wen  = 1'b0;
    w_bet_idx  = r_bet_idx;
    w_bet_data = r_bet_data;
    w_spin_req = 1'b0;
    w_result   = r_result;
    w_payout   = 1'b0;
    w_clear    = 1'b0;
    w_reject   = 1'b0;

    case (r_state)
      ST_BETTING: begin
        if (bus.key_valid) begin
          case (bus.bet_opcode)
            OP_NONE: ;
            OP_SPIN: begin
              if (r_count != 4'd0) begin
                w_state    = ST_SPIN;
                w_spin_req = 1'b1;
                w_timer    = '0;
              end else begin
                w_reject = 1'b1;
              end
            end
            OP_CLEAR: begin
              w_clear = 1'b1;
              w_count = '0;
            end
            default: begin
              if ((bus.chip_color == 3'b000) || (r_count == MAX_CNT)) begin
                w_reject = 1'b1;
              end else begin
                w_bet_wen  = 1'b1;
                w_bet_idx  = r_count;
                w_bet_data = {bus.chip_color[1:0], bus.bet_opcode};
                w_count    = r_count + 4'd1;
              end
            end
          endcase
        end
      end

      ST_SPIN: begin
        w_timer = r_timer + 32'd1;
        if (w_valid_spin) begin
          // A valid result beats a timeout landing on the same cycle.
          w_result = bus.result_number;
          w_state  = ST_SETTLE;
          w_payout = 1'b1;
        end else if (r_timer == SPIN_TIMEOUT - 32'd1) begin
          w_reject = 1'b1;
          w_state  = ST_BETTING;
        end else begin
          w_spin_req = 1'b1;
        end
      end

      ST_SETTLE: w_state = ST_PAYOUT;

      ST_PAYOUT: begin
        if (bus.payout_done) begin
          w_state = ST_HOLD;
          w_timer = '0;
        end
      end

      ST_HOLD: begin
        w_timer = r_timer + 32'd1;
        if (r_timer == DISPLAY_CYCLES - 32'd1) begin
          w_state = ST_CLEAR;
          w_clear = 1'b1;
          w_count = '0;
        end
      end

      ST_CLEAR: w_state = ST_BETTING;

      default: w_state = ST_BETTING;
    endcase
  end

  assign bus.bet_wen      = r_bet_wen;
  assign bus.bet_idx      = r_bet_idx;
  assign bus.bet_data     = r_bet_data;
  assign bus.bet_count    = r_count;
  assign bus.spin_req     = r_spin_req;
  assign bus.result_latch = r_result;
  assign bus.payout_start = r_payout;
  assign bus.clear_bets   = r_clear;
  assign bus.reject       = r_reject;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_roulette_round_controller.sv
// Scenario-driven bench for roulette_round_controller with a bet-write scoreboard.
module tb_roulette_round_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  roulette_round_controller_if bus();

  roulette_round_controller #(
    .MAX_BETS      (12),
    .SPIN_TIMEOUT  (32'd16),
    .DISPLAY_CYCLES(32'd8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t got;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Mutual exclusion of the four pulse outputs, watched on every falling edge.
  always @(negedge clock) begin
    if (reset) begin
      n_cmp++;
      if ($countones({bus.bet_wen, bus.reject, bus.clear_bets, bus.payout_start}) > 1) begin
        n_bad++;
        $display("FAIL pulse_exclusive got wen=%0b rej=%0b clr=%0b pay=%0b want at most one",
                 bus.bet_wen, bus.reject, bus.clear_bets, bus.payout_start);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [5:0] op, input logic [2:0] chip);
    bus.key_valid  = 1'b1;
    bus.bet_opcode = op;
    bus.chip_color = chip;
    step();
    bus.key_valid  = 1'b0;
    bus.bet_opcode = 6'h3F;
    bus.chip_color = 3'b000;
  endtask

  task automatic pulse_spin(input logic [5:0] num);
    bus.spin_done     = 1'b1;
    bus.result_number = num;
    step();
    bus.spin_done     = 1'b0;
    bus.result_number = 6'd0;
  endtask

  task automatic pulse_payout();
    bus.payout_done = 1'b1;
    step();
    bus.payout_done = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b0;
    #2;
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", bus.state); end
    n_cmp++; if ({bus.bet_wen, bus.spin_req, bus.payout_start, bus.clear_bets, bus.reject} !== 5'b0) begin n_bad++; $display("FAIL reset_pulses got %b want 00000", {bus.bet_wen, bus.spin_req, bus.payout_start, bus.clear_bets, bus.reject}); end
    n_cmp++; if (bus.bet_count !== 4'd0 || bus.result_latch !== 6'd0) begin n_bad++; $display("FAIL reset_regs got cnt=%0d res=%0d want 0/0", bus.bet_count, bus.result_latch); end
    apply_reset();
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back('{idx: 4'(i), data: 8'h85});
      press(6'd5, 3'b010);
      n_cmp++;
      if (bus.bet_wen !== 1'b1 || exp_q.size() == 0) begin
        n_bad++; $display("FAIL fill_wen[%0d] got %b want 1", i, bus.bet_wen);
      end else begin
        got = exp_q.pop_front();
        if (bus.bet_idx !== got.idx || bus.bet_data !== got.data) begin
          n_bad++; $display("FAIL fill_write[%0d] got idx=%0d data=%h want idx=%0d data=%h", i, bus.bet_idx, bus.bet_data, got.idx, got.data);
        end
      end
      n_cmp++; if (bus.bet_count !== 4'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.bet_count, i + 1); end
    end
    press(6'd5, 3'b010);
    n_cmp++; if (bus.reject !== 1'b1 || bus.bet_wen !== 1'b0) begin n_bad++; $display("FAIL full_reject got rej=%b wen=%b want 1/0", bus.reject, bus.bet_wen); end
    n_cmp++; if (bus.bet_count !== 4'd12) begin n_bad++; $display("FAIL full_count got %0d want 12", bus.bet_count); end
    step();
    n_cmp++; if (bus.reject !== 1'b0) begin n_bad++; $display("FAIL reject_one_cycle got %b want 0", bus.reject); end
  endtask

  task automatic test_spin_reject();
    apply_reset();
    press(6'h3E, 3'b000);
    n_cmp++; if (bus.reject !== 1'b1 || bus.state !== 3'd0 || bus.spin_req !== 1'b0) begin n_bad++; $display("FAIL empty_spin got rej=%b st=%0d req=%b want 1/0/0", bus.reject, bus.state, bus.spin_req); end
    press(6'd7, 3'b000);
    n_cmp++; if (bus.reject !== 1'b1 || bus.bet_wen !== 1'b0 || bus.bet_count !== 4'd0) begin n_bad++; $display("FAIL no_chip got rej=%b wen=%b cnt=%0d want 1/0/0", bus.reject, bus.bet_wen, bus.bet_count); end
    press(6'h3F, 3'b011);
    n_cmp++; if (bus.reject !== 1'b0 || bus.bet_wen !== 1'b0) begin n_bad++; $display("FAIL no_key got rej=%b wen=%b want 0/0", bus.reject, bus.bet_wen); end
  endtask

  task automatic test_full_round();
    int cyc;
    apply_reset();
    exp_q.push_back('{idx: 4'd0, data: {2'b11, 6'd22}});
    press(6'd22, 3'b111);
    n_cmp++;
    if (bus.bet_wen !== 1'b1 || exp_q.size() == 0) begin
      n_bad++; $display("FAIL round_bet got wen=%b want 1", bus.bet_wen);
    end else begin
      got = exp_q.pop_front();
      if (bus.bet_idx !== got.idx || bus.bet_data !== got.data) begin n_bad++; $display("FAIL round_write got idx=%0d data=%h want idx=%0d data=%h", bus.bet_idx, bus.bet_data, got.idx, got.data); end
    end
    press(6'h3E, 3'b000);
    n_cmp++; if (bus.spin_req !== 1'b1 || bus.state !== 3'd1) begin n_bad++; $display("FAIL spin_enter got req=%b st=%0d want 1/1", bus.spin_req, bus.state); end
    pulse_spin(6'd40);
    n_cmp++; if (bus.state !== 3'd1 || bus.spin_req !== 1'b1 || bus.result_latch !== 6'd0) begin n_bad++; $display("FAIL bad_result got st=%0d req=%b res=%0d want 1/1/0", bus.state, bus.spin_req, bus.result_latch); end
    pulse_spin(6'd17);
    n_cmp++; if (bus.state !== 3'd2 || bus.result_latch !== 6'd17 || bus.spin_req !== 1'b0 || bus.payout_start !== 1'b1) begin n_bad++; $display("FAIL settle got st=%0d res=%0d req=%b pay=%b want 2/17/0/1", bus.state, bus.result_latch, bus.spin_req, bus.payout_start); end
    step();
    n_cmp++; if (bus.state !== 3'd3 || bus.payout_start !== 1'b0) begin n_bad++; $display("FAIL payout got st=%0d pay=%b want 3/0", bus.state, bus.payout_start); end
    step(); step();
    pulse_payout();
    n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL hold_enter got %0d want 4", bus.state); end
    cyc = 0;
    while (bus.clear_bets !== 1'b1 && cyc < 40) begin step(); cyc++; end
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL hold_cycles got %0d want 8", cyc); end
    n_cmp++; if (bus.bet_count !== 4'd0 || bus.state !== 3'd5 || bus.result_latch !== 6'd17) begin n_bad++; $display("FAIL clear_state got cnt=%0d st=%0d res=%0d want 0/5/17", bus.bet_count, bus.state, bus.result_latch); end
    step();
    n_cmp++; if (bus.state !== 3'd0 || bus.clear_bets !== 1'b0 || bus.result_latch !== 6'd17) begin n_bad++; $display("FAIL back_to_betting got st=%0d clr=%b res=%0d want 0/0/17", bus.state, bus.clear_bets, bus.result_latch); end
  endtask

  task automatic test_timeout();
    int cyc;
    apply_reset();
    press(6'd3, 3'b001);
    press(6'h3E, 3'b000);
    cyc = 0;
    while (bus.spin_req === 1'b1 && cyc < 40) begin step(); cyc++; end
    n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL timeout_cycles got %0d want 16", cyc); end
    n_cmp++; if (bus.reject !== 1'b1 || bus.state !== 3'd0 || bus.bet_count !== 4'd1) begin n_bad++; $display("FAIL timeout_abort got rej=%b st=%0d cnt=%0d want 1/0/1", bus.reject, bus.state, bus.bet_count); end
    press(6'h3E, 3'b000);
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (bus.state !== 3'd1 || bus.spin_req !== 1'b1) begin n_bad++; $display("FAIL pre_timeout got st=%0d req=%b want 1/1", bus.state, bus.spin_req); end
    pulse_spin(6'd9);
    n_cmp++; if (bus.state !== 3'd2 || bus.reject !== 1'b0 || bus.result_latch !== 6'd9) begin n_bad++; $display("FAIL timeout_race got st=%0d rej=%b res=%0d want 2/0/9", bus.state, bus.reject, bus.result_latch); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    press(6'd3, 3'b001);
    press(6'h3E, 3'b000);
    step();
    press(6'd4, 3'b010);
    n_cmp++; if (bus.bet_wen !== 1'b0 || bus.reject !== 1'b0 || bus.bet_count !== 4'd1) begin n_bad++; $display("FAIL key_in_spin got wen=%b rej=%b cnt=%0d want 0/0/1", bus.bet_wen, bus.reject, bus.bet_count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0 || bus.spin_req !== 1'b0 || bus.bet_count !== 4'd0) begin n_bad++; $display("FAIL reset_mid_spin got st=%0d req=%b cnt=%0d want 0/0/0", bus.state, bus.spin_req, bus.bet_count); end
    step();
    reset = 1'b1;
    press(6'd3, 3'b001);
    press(6'h3E, 3'b000);
    pulse_spin(6'd20);
    step();
    press(6'd4, 3'b010);
    n_cmp++; if (bus.bet_wen !== 1'b0 || bus.reject !== 1'b0 || bus.state !== 3'd3) begin n_bad++; $display("FAIL key_in_payout got wen=%b rej=%b st=%0d want 0/0/3", bus.bet_wen, bus.reject, bus.state); end
    pulse_payout();
    step(); step();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0 || bus.result_latch !== 6'd0 || bus.bet_count !== 4'd0) begin n_bad++; $display("FAIL reset_mid_hold got st=%0d res=%0d cnt=%0d want 0/0/0", bus.state, bus.result_latch, bus.bet_count); end
    step();
    reset = 1'b1;
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 0; i < 3; i++) press(6'(10 + i), 3'b100);
    n_cmp++; if (bus.bet_count !== 4'd3) begin n_bad++; $display("FAIL pre_clear_count got %0d want 3", bus.bet_count); end
    press(6'h3D, 3'b000);
    n_cmp++; if (bus.clear_bets !== 1'b1 || bus.bet_count !== 4'd0 || bus.bet_wen !== 1'b0 || bus.state !== 3'd0) begin n_bad++; $display("FAIL clear_op got clr=%b cnt=%0d wen=%b st=%0d want 1/0/0/0", bus.clear_bets, bus.bet_count, bus.bet_wen, bus.state); end
    exp_q.push_back('{idx: 4'd0, data: {2'b01, 6'd33}});
    press(6'd33, 3'b101);
    n_cmp++;
    if (bus.bet_wen !== 1'b1 || exp_q.size() == 0) begin
      n_bad++; $display("FAIL after_clear_wen got %b want 1", bus.bet_wen);
    end else begin
      got = exp_q.pop_front();
      if (bus.bet_idx !== got.idx || bus.bet_data !== got.data) begin n_bad++; $display("FAIL after_clear_write got idx=%0d data=%h want idx=%0d data=%h", bus.bet_idx, bus.bet_data, got.idx, got.data); end
    end
  endtask

  initial begin
    bus.key_valid     = 1'b0;
    bus.bet_opcode    = 6'h3F;
    bus.chip_color    = 3'b000;
    bus.spin_done     = 1'b0;
    bus.result_number = 6'd0;
    bus.payout_done   = 1'b0;
    test_reset();
    test_fill();
    test_spin_reject();
    test_full_round();
    test_timeout();
    test_async_reset();
    test_clear();
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
